// File: rtl/itcm_port_arb_pkg.sv
// itcm_port_arb_pkg
//   Shared definitions for the ITCM port arbiter: read-response owner
//   encoding, byte-enable width and starvation counter width.
package itcm_port_arb_pkg;

  // Owner of the read whose data returns from the SRAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DS   = 2'd2,
    OWN_DB   = 2'd3
  } rd_own_e;

  localparam int              BE_W         = 4;
  localparam logic [BE_W-1:0] BE_FULL      = 4'hF;

  // Wide enough for the largest legal STARVE_MAX (15).
  localparam int              STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt
//   Saturating counter of consecutive denied fetch-request cycles.
//   Ports:
//     cpu_clk, cpu_rstn  clock, async active-low reset
//     clr_i              clear to zero (wins over increment)
//     inc_i              increment, saturating at STARVE_MAX
//     sat_o              counter currently equals STARVE_MAX
module arb_starve_cnt
  import itcm_port_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/itcm_port_arb.sv
// itcm_port_arb
//   Single-port ITCM arbiter for fetch (if_*), load/store (ds_*) and debug
//   (db_*) requesters. Grants combinationally (debug > data > fetch, with a
//   starvation override letting fetch beat data), drives the SRAM port from
//   the granted requester and steers next-cycle read data to its owner.
//   Ports:
//     cpu_clk, cpu_rstn           clock, async active-low reset
//     dbg_mode_i                  core halted in debug; blocks fetch grants
//     if_*                        fetch read port, plus if_stall_o
//     ds_*                        data port (byte-enabled writes)
//     db_*                        debug port (full-word writes)
//     itcm_*                      SRAM port; itcm_rdata_i is one cycle late
module itcm_port_arb
  import itcm_port_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ITCM_AW    = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  dbg_mode_i,

  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_stall_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,

  input  logic                  ds_req_i,
  input  logic                  ds_we_i,
  input  logic [BE_W-1:0]       ds_be_i,
  input  logic [ADDR_WIDTH-1:0] ds_addr_i,
  input  logic [DATA_WIDTH-1:0] ds_wdata_i,
  output logic                  ds_gnt_o,
  output logic                  ds_rvalid_o,
  output logic [DATA_WIDTH-1:0] ds_rdata_o,

  input  logic                  db_req_i,
  input  logic                  db_we_i,
  input  logic [ADDR_WIDTH-1:0] db_addr_i,
  input  logic [DATA_WIDTH-1:0] db_wdata_i,
  output logic                  db_gnt_o,
  output logic                  db_rvalid_o,
  output logic [DATA_WIDTH-1:0] db_rdata_o,

  output logic                  itcm_cs_o,
  output logic                  itcm_we_o,
  output logic [BE_W-1:0]       itcm_be_o,
  output logic [ITCM_AW-1:0]    itcm_addr_o,
  output logic [DATA_WIDTH-1:0] itcm_wdata_o,
  input  logic [DATA_WIDTH-1:0] itcm_rdata_i
);

  rd_own_e rd_own_q;
  rd_own_e rd_own_d;
  logic    starve_sat;
  logic    force_if;

  // Byte-offset and above-ITCM address bits are intentionally ignored.
  logic    unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i, ds_addr_i, db_addr_i};

  // Fetch jumps ahead of data only once it has been denied STARVE_MAX times.
  assign force_if = starve_sat && if_req_i && !dbg_mode_i;

  assign db_gnt_o   = db_req_i;
  assign ds_gnt_o   = ds_req_i && !db_req_i && !force_if;
  assign if_gnt_o   = if_req_i && !dbg_mode_i && !db_req_i && (!ds_req_i || force_if);
  assign if_stall_o = if_req_i && !if_gnt_o;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .clr_i    (if_gnt_o || !if_req_i || dbg_mode_i),
    .inc_i    (if_req_i && !if_gnt_o && !dbg_mode_i),
    .sat_o    (starve_sat)
  );

  always_comb begin
    itcm_cs_o    = 1'b0;
    itcm_we_o    = 1'b0;
    itcm_be_o    = '0;
    itcm_addr_o  = '0;
    itcm_wdata_o = '0;
    rd_own_d     = OWN_NONE;
    if (db_gnt_o) begin
      itcm_cs_o    = 1'b1;
      itcm_we_o    = db_we_i;
      itcm_be_o    = BE_FULL;
      itcm_addr_o  = db_addr_i[ITCM_AW+1:2];
      itcm_wdata_o = db_wdata_i;
      if (!db_we_i) rd_own_d = OWN_DB;
    end else if (ds_gnt_o) begin
      itcm_cs_o    = 1'b1;
      itcm_we_o    = ds_we_i;
      itcm_be_o    = ds_we_i ? ds_be_i : BE_FULL;
      itcm_addr_o  = ds_addr_i[ITCM_AW+1:2];
      itcm_wdata_o = ds_wdata_i;
      if (!ds_we_i) rd_own_d = OWN_DS;
    end else if (if_gnt_o) begin
      itcm_cs_o    = 1'b1;
      itcm_be_o    = BE_FULL;
      itcm_addr_o  = if_addr_i[ITCM_AW+1:2];
      rd_own_d     = OWN_IF;
    end
  end

  // Reset clears the owner, so a read in flight at reset never reports valid.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rd_own_q <= OWN_NONE;
    end else begin
      rd_own_q <= rd_own_d;
    end
  end

  assign if_rvalid_o = (rd_own_q == OWN_IF);
  assign ds_rvalid_o = (rd_own_q == OWN_DS);
  assign db_rvalid_o = (rd_own_q == OWN_DB);

  assign if_rdata_o  = itcm_rdata_i;
  assign ds_rdata_o  = itcm_rdata_i;
  assign db_rdata_o  = itcm_rdata_i;

endmodule

// File: tb/tb_itcm_port_arb.sv
// tb_itcm_port_arb
//   Randomized and directed stimulus for itcm_port_arb, checked every cycle
//   against a priority-list reference model of grants, starvation count and
//   read-response ownership.
module tb_itcm_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IAW = 14;
  localparam int STARVE_MAX = 4;

  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b0;
  logic dbg_mode = 1'b0;
  logic if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic if_gnt, if_stall, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic ds_req = 1'b0, ds_we = 1'b0;
  logic [3:0] ds_be = '0;
  logic [AW-1:0] ds_addr = '0;
  logic [DW-1:0] ds_wdata = '0;
  logic ds_gnt, ds_rvalid;
  logic [DW-1:0] ds_rdata;
  logic db_req = 1'b0, db_we = 1'b0;
  logic [AW-1:0] db_addr = '0;
  logic [DW-1:0] db_wdata = '0;
  logic db_gnt, db_rvalid;
  logic [DW-1:0] db_rdata;
  logic itcm_cs, itcm_we;
  logic [3:0] itcm_be;
  logic [IAW-1:0] itcm_addr;
  logic [DW-1:0] itcm_wdata;
  logic [DW-1:0] itcm_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: 0 none, 1 fetch, 2 data, 3 debug
  int m_starve = 0;
  int m_own = 0;

  // values captured at the last checked negedge
  logic cap_if_gnt, cap_ds_gnt, cap_db_gnt, cap_cs, cap_we, cap_stall;
  logic cap_if_rv, cap_ds_rv, cap_db_rv;
  logic [3:0] cap_be;
  logic [IAW-1:0] cap_addr;
  logic [DW-1:0] cap_if_rdata;

  itcm_port_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ITCM_AW    (IAW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rstn     (cpu_rstn),
    .dbg_mode_i   (dbg_mode),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_stall_o   (if_stall),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .ds_req_i     (ds_req),
    .ds_we_i      (ds_we),
    .ds_be_i      (ds_be),
    .ds_addr_i    (ds_addr),
    .ds_wdata_i   (ds_wdata),
    .ds_gnt_o     (ds_gnt),
    .ds_rvalid_o  (ds_rvalid),
    .ds_rdata_o   (ds_rdata),
    .db_req_i     (db_req),
    .db_we_i      (db_we),
    .db_addr_i    (db_addr),
    .db_wdata_i   (db_wdata),
    .db_gnt_o     (db_gnt),
    .db_rvalid_o  (db_rvalid),
    .db_rdata_o   (db_rdata),
    .itcm_cs_o    (itcm_cs),
    .itcm_we_o    (itcm_we),
    .itcm_be_o    (itcm_be),
    .itcm_addr_o  (itcm_addr),
    .itcm_wdata_o (itcm_wdata),
    .itcm_rdata_i (itcm_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Winner from an ordered priority list: 0 none, 1 fetch, 2 data, 3 debug.
  function automatic int pick(bit dbr, bit dsr, bit ifr, bit dbg, int starve);
    int order[3];
    bit want[4];
    want[0] = 1'b0;
    want[1] = ifr && !dbg;
    want[2] = dsr;
    want[3] = dbr;
    if (starve == STARVE_MAX && ifr && !dbg) order = '{3, 1, 2};
    else                                     order = '{3, 2, 1};
    for (int k = 0; k < 3; k++)
      if (want[order[k]]) return order[k];
    return 0;
  endfunction

  // One clock: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    int w;
    logic e_we;
    logic [3:0] e_be;
    logic [IAW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    #1;
    w = pick(db_req, ds_req, if_req, dbg_mode, m_starve);
    e_we = 1'b0; e_be = 4'h0; e_addr = '0; e_wdata = '0;
    case (w)
      1: begin e_be = 4'hF; e_addr = IAW'(if_addr / 4); end
      2: begin e_we = ds_we; e_be = ds_we ? ds_be : 4'hF; e_addr = IAW'(ds_addr / 4); e_wdata = ds_wdata; end
      3: begin e_we = db_we; e_be = 4'hF; e_addr = IAW'(db_addr / 4); e_wdata = db_wdata; end
      default: ;
    endcase
    @(negedge cpu_clk);
    check_val("grants", {db_gnt, ds_gnt, if_gnt}, {w == 3, w == 2, w == 1});
    check_val("if_stall", if_stall, if_req && (w != 1));
    check_val("itcm_cs", itcm_cs, w != 0);
    check_val("itcm_we", itcm_we, e_we);
    check_val("itcm_be", itcm_be, e_be);
    check_val("itcm_addr", itcm_addr, e_addr);
    check_val("itcm_wdata", itcm_wdata, e_wdata);
    check_val("rvalids", {db_rvalid, ds_rvalid, if_rvalid}, {m_own == 3, m_own == 2, m_own == 1});
    check_val("starve_cnt", dut.u_starve.cnt_q, m_starve);
    if (m_own == 1) check_val("if_rdata", if_rdata, itcm_rdata);
    if (m_own == 2) check_val("ds_rdata", ds_rdata, itcm_rdata);
    if (m_own == 3) check_val("db_rdata", db_rdata, itcm_rdata);
    cap_if_gnt = if_gnt; cap_ds_gnt = ds_gnt; cap_db_gnt = db_gnt;
    cap_cs = itcm_cs; cap_we = itcm_we; cap_be = itcm_be; cap_addr = itcm_addr;
    cap_stall = if_stall; cap_if_rv = if_rvalid; cap_ds_rv = ds_rvalid; cap_db_rv = db_rvalid;
    cap_if_rdata = if_rdata;
    @(posedge cpu_clk);
    if (w == 1 || !if_req || dbg_mode) m_starve = 0;
    else if (m_starve < STARVE_MAX)    m_starve = m_starve + 1;
    if      (w == 1)           m_own = 1;
    else if (w == 2 && !ds_we) m_own = 2;
    else if (w == 3 && !db_we) m_own = 3;
    else                       m_own = 0;
    #1;
  endtask

  task automatic idle_inputs();
    dbg_mode = 1'b0; if_req = 1'b0; ds_req = 1'b0; ds_we = 1'b0; db_req = 1'b0; db_we = 1'b0;
  endtask

  initial begin
    int seq[6];
    seq = '{0, 1, 2, 3, 4, 0};

    // reset: everything quiet
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check_val("rst_rvalids", {db_rvalid, ds_rvalid, if_rvalid}, 3'b000);
    check_val("rst_grants", {db_gnt, ds_gnt, if_gnt}, 3'b000);
    check_val("rst_itcm", {itcm_cs, itcm_we, itcm_be, itcm_addr}, '0);
    check_val("rst_starve", dut.u_starve.cnt_q, 0);
    cpu_rstn = 1'b1;
    @(posedge cpu_clk); #1;

    // fetch read of 0x10, data 0x13 returned next cycle
    if_req = 1'b1; if_addr = 32'h0000_0010;
    step();
    check_val("tp1_addr", cap_addr, 4);
    check_val("tp1_cs", cap_cs, 1);
    if_req = 1'b0; itcm_rdata = 32'h0000_0013;
    step();
    check_val("tp1_rvalid", cap_if_rv, 1);
    check_val("tp1_rdata", cap_if_rdata, 32'h13);

    // all three request at once: debug only
    db_req = 1'b1; ds_req = 1'b1; if_req = 1'b1; db_addr = 32'h100; ds_addr = 32'h200; if_addr = 32'h300;
    step();
    check_val("tp2_grants", {cap_db_gnt, cap_ds_gnt, cap_if_gnt}, 3'b100);
    check_val("tp2_stall", cap_stall, 1);
    idle_inputs();
    step();

    // data vs fetch held: counter 0,1,2,3,4,0 and fetch wins on the fifth
    ds_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_val("tp3_cnt", dut.u_starve.cnt_q, seq[i]);
      step();
      check_val("tp3_if_gnt", cap_if_gnt, i == 4);
    end
    idle_inputs();
    step();

    // fetch blocked in debug mode, granted once it drops
    dbg_mode = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("tp4_if_gnt", cap_if_gnt, 0);
      check_val("tp4_cnt", dut.u_starve.cnt_q, 0);
    end
    dbg_mode = 1'b0;
    step();
    check_val("tp4_release", cap_if_gnt, 1);

    // dbg_mode rising with a fetch read outstanding still delivers it
    dbg_mode = 1'b1; if_req = 1'b0; itcm_rdata = 32'hCAFE_0001;
    step();
    check_val("dbg_rise_rvalid", cap_if_rv, 1);
    idle_inputs();
    step();

    // data write then read of 0x20
    ds_req = 1'b1; ds_we = 1'b1; ds_be = 4'b0011; ds_addr = 32'h20; ds_wdata = 32'h1234_5678;
    step();
    check_val("tp5_we", cap_we, 1);
    check_val("tp5_be", cap_be, 4'b0011);
    ds_we = 1'b0;
    step();
    check_val("tp5_wr_no_rvalid", {cap_db_rv, cap_ds_rv, cap_if_rv}, 3'b000);
    ds_req = 1'b0; itcm_rdata = 32'h0000_5678;
    step();
    check_val("tp5_rd_rvalid", cap_ds_rv, 1);

    // randomized traffic with requesters mostly holding until granted
    for (int c = 0; c < 2000; c++) begin
      if (!(if_req && !cap_if_gnt) || $urandom_range(9) == 0) begin
        if_req = ($urandom_range(9) < 7); if_addr = $urandom;
      end
      if (!(ds_req && !cap_ds_gnt) || $urandom_range(9) == 0) begin
        ds_req = ($urandom_range(9) < 6); ds_we = $urandom_range(1);
        ds_be = 4'($urandom); ds_addr = $urandom; ds_wdata = $urandom;
      end
      db_req = ($urandom_range(9) == 0); db_we = $urandom_range(1);
      db_addr = $urandom; db_wdata = $urandom;
      if ($urandom_range(19) == 0) dbg_mode = ~dbg_mode;
      itcm_rdata = $urandom;
      step();
    end
    idle_inputs();
    step();

    // reset asserted while a debug read is in flight
    db_req = 1'b1; db_we = 1'b0; db_addr = 32'h40;
    #1;
    @(negedge cpu_clk);
    check_val("rst_mid_gnt", db_gnt, 1);
    cpu_rstn = 1'b0;
    @(posedge cpu_clk); #1;
    check_val("rst_mid_rvalid", db_rvalid, 0);
    db_req = 1'b0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check_val("rst_hold_rvalid", db_rvalid, 0);
    cpu_rstn = 1'b1;
    m_own = 0; m_starve = 0;
    @(posedge cpu_clk); #1;
    check_val("rst_after_rvalid", db_rvalid, 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
